return_stack: RTL and testbench

- Hardware return-address stack for subroutine CALL/RET in the 8-bit processor.
- Sits beside the PC register:
  - consumes the PC+1 value produced by the PC adder on CALL;
  - on RET, supplies the saved address back to the PC-select mux.
- LIFO with combinational top-of-stack read, full/empty status and sticky overflow/underflow error flags.

---
 rtl/return_stack_pkg.sv | 27 ++
 rtl/return_stack_if.sv | 30 +++
 rtl/return_stack_stack_ram.sv | 25 ++
 rtl/return_stack.sv | 113 +++++++++++
 tb/tb_return_stack.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/return_stack_pkg.sv
// rtl/return_stack_pkg.sv - shared constants and CALL/RET opcode encodings for the return stack
package return_stack_pkg;

    localparam int PC_WIDTH    = 10;
    localparam int STACK_DEPTH = 8;

    // Controller-side opcodes that decode into the push/pop strobes.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_CALL = 2'b01,
        OP_RET  = 2'b10,
        OP_TAIL = 2'b11
    } rs_op_e;

    typedef struct packed {
        logic push;
        logic pop;
    } rs_ctl_t;

    function automatic rs_ctl_t rs_decode(input rs_op_e op);
        rs_ctl_t c;
        c.push = (op == OP_CALL) || (op == OP_TAIL);
        c.pop  = (op == OP_RET)  || (op == OP_TAIL);
        return c;
    endfunction

endpackage

// File: rtl/return_stack_if.sv
// rtl/return_stack_if.sv - push/pop request and stack status bundle between controller and stack
interface return_stack_if
    import return_stack_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = STACK_DEPTH
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             unf;

    modport master (
        output push, pop, d,
        input  q, empty, full, count, ovf, unf
    );

    modport slave (
        input  push, pop, d,
        output q, empty, full, count, ovf, unf
    );

endinterface

// File: rtl/return_stack_stack_ram.sv
// rtl/return_stack_stack_ram.sv - DEPTH x WIDTH storage, one synchronous write, one combinational read
module stack_ram #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/return_stack.sv
// rtl/return_stack.sv - CALL/RET return-address LIFO with sticky ovf/unf; RSTACK_WRAP_EN selects circular storage
module return_stack
    import return_stack_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    return_stack_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_IX = AW'(DEPTH - 1);

    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_unf;
    logic [AW-1:0]    w_base;
    logic [CW:0]      w_sum;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_waddr;
    logic             w_we;
    logic             w_empty;
    logic             w_full;
    logic             w_tail;
    logic             w_full_push;
    logic [WIDTH-1:0] w_rd_data;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == DEPTH_C);
    assign w_tail      = bus.push && bus.pop && !w_empty;
    assign w_full_push = bus.push && !bus.pop && w_full;

    // Next free slot is base+count modulo DEPTH; the top entry sits just below it.
    assign w_sum     = {{(CW + 1 - AW){1'b0}}, w_base} + {1'b0, r_count};
    assign w_wr_idx  = (w_sum >= DEPTH_W) ? AW'(w_sum - DEPTH_W) : AW'(w_sum);
    assign w_top_idx = (w_wr_idx == '0) ? LAST_IX : w_wr_idx - AW'(1);
    assign w_waddr   = w_tail ? w_top_idx : w_wr_idx;

`ifdef RSTACK_WRAP_EN
    logic [AW-1:0] r_base;

    assign w_base = r_base;
    assign w_we   = bus.push;

    // A full push lands on the oldest slot, which then becomes the newest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base <= '0;
        end else if (w_full_push) begin
            r_base <= (r_base == LAST_IX) ? '0 : r_base + AW'(1);
        end
    end
`else
    assign w_base = '0;
    assign w_we   = bus.push && !w_full_push;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (bus.push && bus.pop) begin
                if (w_empty) begin
                    r_count <= CW'(1);
                    r_unf   <= 1'b1;
                end
            end else if (bus.push) begin
                if (!w_full) begin
                    r_count <= r_count + CW'(1);
                end else begin
`ifndef RSTACK_WRAP_EN
                    r_ovf <= 1'b1;
`endif
                end
            end else if (bus.pop) begin
                if (w_empty) begin
                    r_unf <= 1'b1;
                end else begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (bus.d),
        .i_raddr (w_top_idx),
        .o_rdata (w_rd_data)
    );

    assign bus.q     = w_empty ? '0 : w_rd_data;
    assign bus.empty = w_empty;
    assign bus.full  = w_full;
    assign bus.count = r_count;
    assign bus.ovf   = r_ovf;
    assign bus.unf   = r_unf;

endmodule

// File: tb/tb_return_stack.sv
// tb/tb_return_stack.sv - directed table-driven bench for return_stack; honours RSTACK_WRAP_EN
module tb_return_stack;
    import return_stack_pkg::*;

    localparam int W = 10;
    localparam int D = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    return_stack_if #(.WIDTH(W), .DEPTH(D)) rs ();

    return_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rs.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        rs_op_e      op;
        logic [9:0]  d;
        logic [9:0]  q;
        logic [3:0]  count;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } vec_t;

    function automatic logic [17:0] pack_exp(input logic [9:0] q, input logic [3:0] c,
                                             input logic e, input logic f,
                                             input logic o, input logic u);
        return {q, c, e, f, o, u};
    endfunction

    function automatic logic [17:0] pack_dut();
        return {rs.q, rs.count, rs.empty, rs.full, rs.ovf, rs.unf};
    endfunction

    task automatic check(input string name, input logic [17:0] exp);
        logic [17:0] act;
        act = pack_dut();
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got q=%h count=%0d empty=%b full=%b ovf=%b unf=%b, want q=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
                     name, act[17:8], act[7:4], act[3], act[2], act[1], act[0],
                     exp[17:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input rs_op_e op, input logic [9:0] d);
        rs_ctl_t c;
        c = rs_decode(op);
        @(negedge clk);
        rs.push = c.push;
        rs.pop  = c.pop;
        rs.d    = d;
        @(posedge clk);
        #1;
        rs.push = 1'b0;
        rs.pop  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_q;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        rs.push  = 1'b0;
        rs.pop   = 1'b0;
        rs.d     = '0;

        vecs[0] = '{OP_CALL, 10'h005, 10'h005, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{OP_CALL, 10'h012, 10'h012, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{OP_CALL, 10'h3FF, 10'h3FF, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{OP_RET,  10'h000, 10'h012, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{OP_RET,  10'h000, 10'h005, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{OP_RET,  10'h000, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{OP_CALL, 10'h020, 10'h020, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{OP_TAIL, 10'h0AB, 10'h0AB, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{OP_RET,  10'h000, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{OP_NONE, 10'h000, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state after two idle cycles
        do_reset();
        step(OP_NONE, '0);
        step(OP_NONE, '0);
        check("reset_state", pack_exp(10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        // Push/pop ordering and tail-call replacement
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].op, vecs[i].d);
            check($sformatf("vec%0d", i),
                  pack_exp(vecs[i].q, vecs[i].count, vecs[i].empty, vecs[i].full,
                           vecs[i].ovf, vecs[i].unf));
        end

        // Fill past capacity
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            step(OP_CALL, 10'(i));
`ifdef RSTACK_WRAP_EN
            exp_q = 10'(i);
            check($sformatf("fill%0d", i),
                  pack_exp(exp_q, (i >= 8) ? 4'd8 : 4'(i), 1'b0, i >= 8, 1'b0, 1'b0));
`else
            exp_q = (i >= 8) ? 10'h008 : 10'(i);
            check($sformatf("fill%0d", i),
                  pack_exp(exp_q, (i >= 8) ? 4'd8 : 4'(i), 1'b0, i >= 8, i == 9, 1'b0));
`endif
        end
        for (int k = 1; k <= 8; k++) begin
            step(OP_RET, '0);
`ifdef RSTACK_WRAP_EN
            exp_q = (k == 8) ? 10'h000 : 10'(9 - k);
            check($sformatf("drain%0d", k),
                  pack_exp(exp_q, 4'(8 - k), k == 8, 1'b0, 1'b0, 1'b0));
`else
            exp_q = 10'(8 - k);
            check($sformatf("drain%0d", k),
                  pack_exp(exp_q, 4'(8 - k), k == 8, 1'b0, 1'b1, 1'b0));
`endif
        end

        // Underflow is sticky across valid operations
        do_reset();
        step(OP_RET, '0);
        check("unf_pop_empty", pack_exp(10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1));
        step(OP_CALL, 10'h100);
        check("unf_sticky_push", pack_exp(10'h100, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1));
        step(OP_RET, '0);
        check("unf_sticky_pop", pack_exp(10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1));

        // Push+pop on empty acts as a push and flags underflow
        do_reset();
        step(OP_TAIL, 10'h055);
        check("tail_empty", pack_exp(10'h055, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1));

        // Asynchronous reset between edges clears state immediately
        do_reset();
        step(OP_RET, '0);
        step(OP_CALL, 10'h011);
        step(OP_CALL, 10'h022);
        step(OP_CALL, 10'h033);
        check("pre_async", pack_exp(10'h033, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", pack_exp(10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        // Push held during reset is ignored
        rs.push = 1'b1;
        rs.d    = 10'h3AA;
        @(posedge clk);
        #1;
        check("push_in_reset", pack_exp(10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rs.push = 1'b0;
        reset   = 1'b0;
        step(OP_NONE, '0);
        check("post_reset_idle", pack_exp(10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
